mult_div_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit in the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- Supports MTHI/MTLO writes.
- hi/lo outputs feed the 8:1 32-bit writeback/result select mux directly downstream, which MFHI/MFLO use. busy drives the hazard unit's stall.

---
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// holding the architectural HI/LO registers and accepting MTHI/MTLO writes while idle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  // acc: running partial product (upper half) or partial remainder
  logic [WIDTH-1:0]    acc_q, acc_d;
  // quo: multiplier shifting out / dividend shifting out and quotient shifting in
  logic [WIDTH-1:0]    quo_q, quo_d;
  // opnd: multiplicand or divisor (magnitude)
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;

  logic                signed_op;
  logic                rs_neg, rt_neg;
  logic [WIDTH-1:0]    rs_abs, rt_abs;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH+1:0]    div_diff;
  logic [2*WIDTH-1:0]  prod, prod_fix;
  logic [WIDTH-1:0]    quot_fix, rem_fix;

  assign signed_op = ~op[0];
  assign rs_neg    = signed_op & rs_val[WIDTH-1];
  assign rt_neg    = signed_op & rt_val[WIDTH-1];
  assign rs_abs    = rs_neg ? -rs_val : rs_val;
  assign rt_abs    = rt_neg ? -rt_val : rt_val;

  assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, quo_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  assign prod      = {acc_q, quo_q};
  assign prod_fix  = neg_res_q ? -prod : prod;
  assign quot_fix  = neg_res_q ? -quo_q : quo_q;
  assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

  // Next-state: launch/MT writes in idle, one iteration per cycle, sign fix-up and writeback.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          is_div_d  = op[1];
          // Divide by zero leaves the quotient as all ones, so it must not be negated.
          neg_res_d = (rs_neg ^ rt_neg) & ~(op[1] & (rt_val == '0));
          neg_rem_d = op[1] & rs_neg;
          acc_d     = '0;
          quo_d     = op[1] ? rs_abs : rt_abs;
          opnd_d    = op[1] ? rt_abs : rs_abs;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          acc_d = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      quo_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard, then corner sequences.
module tb_mult_div_unit;

  localparam int unsigned W = 32;
  localparam int unsigned BusyCycles = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    bit           poke;   // assert a conflicting start mid-operation
  } vec_t;

  vec_t         vecs[9];
  logic [63:0]  sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    sb_q.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // elapsed: busy cycles already observed since the launch edge
  task automatic wait_done(input string name, input int elapsed);
    int          n;
    logic [63:0] exp;
    n = elapsed;
    while (busy && n <= 100) begin
      @(negedge clk);
      if (busy) n++;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(BusyCycles));
    check({name, "_done"}, 64'(done), 64'd1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", name);
    end else begin
      exp = sb_q.pop_front();
      check({name, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({name, "_lo"}, 64'(lo), 64'(exp[31:0]));
      model_hi = exp[63:32];
      model_lo = exp[31:0];
    end
    @(negedge clk);
    check({name, "_done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{2'b11, 32'h00000064, 32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7] = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b0};
    vecs[8] = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo);
      if (vecs[i].poke) begin
        repeat (3) @(negedge clk);
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd5;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done($sformatf("vec%0d", i), 5);
      end else begin
        wait_done($sformatf("vec%0d", i), 1);
      end
    end

    // MTHI / MTLO in idle
    @(negedge clk);
    mthi  = 1'b1;
    wdata = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", 64'(hi), 64'h12345678);
    model_hi = 32'h12345678;
    mtlo  = 1'b1;
    wdata = 32'hCAFEF00D;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle", 64'(lo), 64'hCAFEF00D);
    check("mtlo_idle_hi_kept", 64'(hi), 64'h12345678);
    model_lo = 32'hCAFEF00D;

    // MTLO while busy is ignored
    launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    mtlo  = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_busy_ignored", 64'(lo), 64'(model_lo));
    check("hi_held_in_calc", 64'(hi), 64'(model_hi));
    wait_done("mtlo_busy", 2);

    // MTHI together with start: write lands, then result overwrites
    @(negedge clk);
    mthi   = 1'b1;
    wdata  = 32'h0BADF00D;
    start  = 1'b1;
    op     = 2'b00;
    rs_val = 32'hFFFFFFFE;
    rt_val = 32'd3;
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    @(negedge clk);
    mthi  = 1'b0;
    start = 1'b0;
    check("mthi_start_hi", 64'(hi), 64'h0BADF00D);
    check("mthi_start_busy", 64'(busy), 64'd1);
    wait_done("mthi_start", 1);

    // Asynchronous reset at counter 10
    launch(2'b01, 32'd1000, 32'd1000, 32'd0, 32'd1000000);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    launch(2'b00, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_done("post_reset_mult", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
